ascii_setpoint_parser: RTL and testbench
========================================

ASCII_SETPOINT_PARSER -- requirements
Module: ascii_setpoint_parser

Parameters
REQ-001 NUM_CH, default 4, number of setpoint channels, legal range 1..8.
REQ-002 MAX_DIGITS, default 3, maximum decimal digits per value, legal range 1..4.
REQ-003 OUT_W, default 13, width of each channel setpoint.
REQ-004 MAX_VAL, default 180, largest legal setpoint value, SHALL fit in OUT_W bits.
REQ-005 DEF_VAL, default 90, value of every channel after reset.

Interface
REQ-006 Clk  in  1  clock; all state changes on rising edge.
REQ-007 Rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Rx_Data  in  8  received ASCII byte.
REQ-009 Rx_Valid  in  1  single-cycle strobe; Rx_Data is valid this cycle.
REQ-010 SetAngleOut  out  NUM_CH*OUT_W  packed setpoints; channel k occupies bits [k*OUT_W +: OUT_W].
REQ-011 Upd_Valid  out  1  one-cycle pulse; one channel was updated.
REQ-012 Upd_Ch  out  3  index of the channel updated; valid while Upd_Valid is high.
REQ-013 Err  out  1  one-cycle pulse; the current frame was rejected.
REQ-014 Err_Code  out  2  rejection reason; valid while Err is high: 1 = illegal or empty, 2 = too many digits, 3 = out of range.

Function
REQ-015 Frame format: channel letter 'A'+k (0x41+k), then 1..MAX_DIGITS digits '0'..'9', then a terminator CR (0x0D) or LF (0x0A).
REQ-016 The block SHALL accept one byte on every cycle in which Rx_Valid=1; there is no backpressure, and bytes with Rx_Valid=0 are ignored.
REQ-017 State machine states: IDLE and DIGITS.
REQ-018 IDLE, byte is 'A'..'A'+NUM_CH-1: latch the channel, clear the accumulator and digit count, go to DIGITS.
REQ-019 IDLE, any other byte (including a terminator or a letter at or beyond NUM_CH): ignore it and stay in IDLE, with no Err pulse.
REQ-020 DIGITS, digit byte with count < MAX_DIGITS: acc <= acc*10 + (byte-0x30) and count+1.
REQ-021 Accumulator width SHALL hold 10^MAX_DIGITS-1 without truncation.
REQ-022 DIGITS, digit byte with count = MAX_DIGITS: pulse Err with Err_Code=2, go to IDLE, leave setpoints unchanged.
REQ-023 DIGITS, terminator with count=0: pulse Err with Err_Code=1, go to IDLE.
REQ-024 DIGITS, terminator with acc > MAX_VAL: pulse Err with Err_Code=3, go to IDLE, leave setpoints unchanged.
REQ-025 DIGITS, terminator with 1 <= count and acc <= MAX_VAL: write acc, zero-extended to OUT_W, into the latched channel; pulse Upd_Valid with Upd_Ch = that channel; go to IDLE.
REQ-026 DIGITS, valid channel letter: abandon the current frame, pulse Err with Err_Code=1, then restart per REQ-018 using this letter (resynchronisation).
REQ-027 DIGITS, any other byte: pulse Err with Err_Code=1, go to IDLE.
REQ-028 Latency: the setpoint register, Upd_Valid/Upd_Ch and Err/Err_Code SHALL all change on the clock edge that samples the terminating or offending byte.
REQ-029 Setpoint, Upd_Valid and Err outputs SHALL be registered, not combinational.
REQ-030 Upd_Valid and Err SHALL never be high in the same cycle.
REQ-031 Only one channel SHALL be written per frame; all other channels hold their value.
REQ-032 Value 0 is legal; leading zeros count toward MAX_DIGITS.

Reset
REQ-033 While Rst_n=0: every channel = DEF_VAL, FSM = IDLE, acc = 0, count = 0, Upd_Valid = 0, Upd_Ch = 0, Err = 0, Err_Code = 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the next frame after release is parsed from IDLE.

Verification (defaults)
REQ-035 Release reset, no input -> all four channels = 90, Upd_Valid and Err stay 0.
REQ-036 Send "B045\n" -> channel 1 = 45, one Upd_Valid pulse with Upd_Ch=1, channels 0/2/3 = 90.
REQ-037 Send "A181\r", then "C1234\n" -> Err_Code=3 pulse, then Err_Code=2 pulse on the 4th digit; all channels unchanged.
REQ-038 Send "A12D7\n" -> Err_Code=1 pulse on 'D', then channel 3 = 7 with Upd_Ch=3; channel 0 = 90.
REQ-039 Send "A\n", then "E5\n", then "x\r\n" -> one Err pulse (Err_Code=1) for "A\n"; the rest is ignored silently; no updates.
REQ-040 Assert Rst_n after "D17", then send "0\n", then "D100\n" -> no update from the "0\n"; channel 3 = 100 after the second frame.

Source files
------------

// File: rtl/ascii_setpoint_parser_if.sv
// ascii_setpoint_parser_if: byte stream in, packed setpoints and update/error pulses out
interface ascii_setpoint_parser_if #(
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 13
);
    logic [7:0]              Rx_Data;
    logic                    Rx_Valid;
    logic [NUM_CH*OUT_W-1:0] SetAngleOut;
    logic                    Upd_Valid;
    logic [2:0]              Upd_Ch;
    logic                    Err;
    logic [1:0]              Err_Code;

    modport master (
        output Rx_Data, Rx_Valid,
        input  SetAngleOut, Upd_Valid, Upd_Ch, Err, Err_Code
    );

    modport slave (
        input  Rx_Data, Rx_Valid,
        output SetAngleOut, Upd_Valid, Upd_Ch, Err, Err_Code
    );
endinterface

// File: rtl/ascii_setpoint_parser.sv
// ascii_setpoint_parser: parses "<letter><digits><CR|LF>" frames into per-channel setpoints
module ascii_setpoint_parser #(
    parameter int NUM_CH     = 4,
    parameter int MAX_DIGITS = 3,
    parameter int OUT_W      = 13,
    parameter int MAX_VAL    = 180,
    parameter int DEF_VAL    = 90
) (
    input logic Clk,
    input logic Rst_n,
    ascii_setpoint_parser_if.slave bus
);
    localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic {IDLE, DIGITS} state_t;

    state_t           state, state_nxt;
    logic [2:0]       ch, ch_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             upd_nxt, err_nxt;
    logic [1:0]       code_nxt;
    logic [7:0]       off;
    logic             is_letter, is_digit, is_term;

    // Byte classes; bytes below 'A' wrap to large offsets and fail the letter test.
    assign off       = bus.Rx_Data - 8'h41;
    assign is_letter = off < 8'(NUM_CH);
    assign is_digit  = bus.Rx_Data >= 8'h30 && bus.Rx_Data <= 8'h39;
    assign is_term   = bus.Rx_Data == 8'h0D || bus.Rx_Data == 8'h0A;

    // Parser state: current channel, decimal accumulator and digit count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            ch    <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and pulse decode; a frame ends in either an update or an error, never both.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        upd_nxt   = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = 2'd0;
        if (bus.Rx_Valid) begin
            if (is_letter) begin
                err_nxt   = state == DIGITS;
                code_nxt  = state == DIGITS ? 2'd1 : 2'd0;
                state_nxt = DIGITS;
                ch_nxt    = off[2:0];
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end else if (state == DIGITS) begin
                state_nxt = IDLE;
                err_nxt   = 1'b1;
                code_nxt  = 2'd1;
                if (is_digit) begin
                    if (cnt == CNT_W'(MAX_DIGITS)) begin
                        code_nxt = 2'd2;
                    end else begin
                        state_nxt = DIGITS;
                        err_nxt   = 1'b0;
                        code_nxt  = 2'd0;
                        acc_nxt   = acc * ACC_W'(10) + ACC_W'(bus.Rx_Data[3:0]);
                        cnt_nxt   = cnt + 1'b1;
                    end
                end else if (is_term && cnt != '0) begin
                    if (32'(acc) > MAX_VAL) begin
                        code_nxt = 2'd3;
                    end else begin
                        err_nxt  = 1'b0;
                        code_nxt = 2'd0;
                        upd_nxt  = 1'b1;
                    end
                end
            end
        end
    end

    // Registered pulses; Upd_Ch and Err_Code read zero outside their pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.Upd_Valid <= 1'b0;
            bus.Upd_Ch    <= 3'd0;
            bus.Err       <= 1'b0;
            bus.Err_Code  <= 2'd0;
        end else begin
            bus.Upd_Valid <= upd_nxt;
            bus.Upd_Ch    <= upd_nxt ? ch : 3'd0;
            bus.Err       <= err_nxt;
            bus.Err_Code  <= code_nxt;
        end
    end

    // Setpoint bank; only the latched channel is written on a good frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < NUM_CH; k++)
                bus.SetAngleOut[k*OUT_W +: OUT_W] <= OUT_W'(DEF_VAL);
        end else begin
            for (int k = 0; k < NUM_CH; k++)
                if (upd_nxt && ch == 3'(k))
                    bus.SetAngleOut[k*OUT_W +: OUT_W] <= OUT_W'(acc);
        end
    end
endmodule

// File: tb/tb_ascii_setpoint_parser.sv
// tb_ascii_setpoint_parser: directed frames with an event scoreboard and setpoint model
module tb_ascii_setpoint_parser;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;

    typedef struct {
        bit is_err;
        int val;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  model[4];

    ascii_setpoint_parser_if #(.NUM_CH(4), .OUT_W(13)) bus ();

    ascii_setpoint_parser #(
        .NUM_CH(4), .MAX_DIGITS(3), .OUT_W(13), .MAX_VAL(180), .DEF_VAL(90)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_sp();
        for (int k = 0; k < 4; k++)
            chk($sformatf("ch%0d", k), 32'(bus.SetAngleOut[k*13 +: 13]), 32'(model[k]));
    endtask

    task automatic send_byte(input byte b);
        bus.Rx_Data  = b;
        bus.Rx_Valid = 1'b1;
        @(negedge Clk);
        bus.Rx_Valid = 1'b0;
        bus.Rx_Data  = 8'h41;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic exp_upd(input int c);
        ev_t e;
        e.is_err = 1'b0;
        e.val    = c;
        q.push_back(e);
    endtask

    task automatic exp_err(input int c);
        ev_t e;
        e.is_err = 1'b1;
        e.val    = c;
        q.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (bus.Upd_Valid || bus.Err) begin
            ev_t e;
            chk("both_pulses", 32'(bus.Upd_Valid & bus.Err), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_event", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("event_kind", 32'(bus.Err), 32'(e.is_err));
                if (e.is_err)
                    chk("err_code", 32'(bus.Err_Code), 32'(e.val));
                else
                    chk("upd_ch", 32'(bus.Upd_Ch), 32'(e.val));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam byte CR = 8'h0D;
        localparam byte LF = 8'h0A;
        bus.Rx_Valid = 1'b0;
        bus.Rx_Data  = 8'h41;
        for (int k = 0; k < 4; k++) model[k] = 90;
        idle(3);
        chk("rst_upd_valid", 32'(bus.Upd_Valid), 32'd0);
        chk("rst_upd_ch", 32'(bus.Upd_Ch), 32'd0);
        chk("rst_err", 32'(bus.Err), 32'd0);
        chk("rst_err_code", 32'(bus.Err_Code), 32'd0);
        check_sp();
        Rst_n = 1'b1;
        idle(5);
        check_sp();

        exp_upd(1);
        send_str("B045"); send_byte(LF);
        model[1] = 45;
        idle(2);
        check_sp();

        exp_err(3);
        send_str("A181"); send_byte(CR);
        exp_err(2);
        send_str("C1234"); send_byte(LF);
        idle(2);
        check_sp();

        exp_err(1);
        exp_upd(3);
        send_str("A12D7"); send_byte(LF);
        model[3] = 7;
        idle(2);
        check_sp();

        exp_err(1);
        send_str("A"); send_byte(LF);
        send_str("E5"); send_byte(LF);
        send_str("x"); send_byte(CR); send_byte(LF);
        idle(2);
        check_sp();

        exp_upd(0);
        send_str("A180"); send_byte(CR);
        model[0] = 180;
        exp_upd(1);
        send_str("B000"); send_byte(LF);
        model[1] = 0;
        exp_upd(2);
        send_str("C0"); send_byte(LF);
        model[2] = 0;
        exp_err(1);
        exp_upd(0);
        send_str("AA3"); send_byte(LF);
        model[0] = 3;
        exp_err(1);
        send_str("Cz"); send_byte(LF);
        idle(2);
        check_sp();

        send_str("D17");
        Rst_n = 1'b0;
        idle(2);
        Rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 4; k++) model[k] = 90;
        check_sp();
        send_str("0"); send_byte(LF);
        exp_upd(3);
        send_str("D100"); send_byte(LF);
        model[3] = 100;
        idle(3);
        check_sp();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
